// File: rtl/video_crop_decim_if.sv
// Raw and processed video stream signals of video_crop_decim.
// The master side drives the raw stream and observes the cropped stream;
// the slave side is the crop/decimation block itself.
interface video_crop_decim_if #(
   parameter int PW = 24
);
   logic          vs_i;
   logic          de_i;
   logic [PW-1:0] rgb_i;
   logic          vs_o;
   logic          de_o;
   logic [PW-1:0] rgb_o;
   logic          sof_o;
   logic          eol_o;

   modport master (
      output vs_i, de_i, rgb_i,
      input  vs_o, de_o, rgb_o, sof_o, eol_o
   );

   modport slave (
      input  vs_i, de_i, rgb_i,
      output vs_o, de_o, rgb_o, sof_o, eol_o
   );
endinterface

// File: rtl/video_crop_decim.sv
// Video crop and power-of-two decimation.
// The crop window and decimation exponents are captured on every vs_i
// rising edge; pixels inside the window whose offset from the window
// origin is a multiple of 2^decim are forwarded one clock later.
module video_crop_decim #(
   parameter int DATA_WIDTH  = 8,
   parameter int CHANNELS    = 3,
   parameter int X_WIDTH     = 12,
   parameter int Y_WIDTH     = 12,
   parameter int DECIM_WIDTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [X_WIDTH-1:0]     start_x,
   input  logic [X_WIDTH-1:0]     end_x,
   input  logic [Y_WIDTH-1:0]     start_y,
   input  logic [Y_WIDTH-1:0]     end_y,
   input  logic [DECIM_WIDTH-1:0] decim_x,
   input  logic [DECIM_WIDTH-1:0] decim_y,
   video_crop_decim_if.slave      vid,
   output logic                   active,
   output logic                   err_o,
   output logic [X_WIDTH-1:0]     out_w,
   output logic [Y_WIDTH-1:0]     out_h
);
   localparam int PW = DATA_WIDTH * CHANNELS;
   localparam logic [X_WIDTH-1:0] X_ONE = X_WIDTH'(1);
   localparam logic [Y_WIDTH-1:0] Y_ONE = Y_WIDTH'(1);

   typedef enum logic [1:0] {IDLE, RUN, BAD} state_t;

   state_t                 state_q, state_d;
   logic                   vs_prev_q, de_prev_q;
   logic [X_WIDTH-1:0]     x_q, x_d, sx_q, sx_d, ex_q, ex_d, out_w_q, out_w_d;
   logic [Y_WIDTH-1:0]     y_q, y_d, sy_q, sy_d, ey_q, ey_d, out_h_q, out_h_d;
   logic [DECIM_WIDTH-1:0] dx_q, dx_d, dy_q, dy_d;
   logic                   sof_pend_q, sof_pend_d;
   logic                   vs_o_q, vs_o_d, de_o_q, de_o_d, sof_o_q, sof_o_d;
   logic                   eol_o_q, eol_o_d, active_q, active_d, err_q, err_d;
   logic [PW-1:0]          rgb_o_q, rgb_o_d;

   logic                   vs_rise, de_fall, win_ok, keep;
   logic [X_WIDTH-1:0]     x_cur, x_off, x_mask, last_x;
   logic [Y_WIDTH-1:0]     y_cur, y_off, y_mask;

   // FSM state register
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state, window evaluation, counters and output next values
   // NOTE: every signal gets a default at the top so no path can infer a latch.
   always_comb begin
      vs_rise    = vid.vs_i & ~vs_prev_q;
      de_fall    = ~vid.de_i & de_prev_q;

      // On a frame-start edge the ports take effect in the same cycle
      sx_d       = vs_rise ? start_x : sx_q;
      ex_d       = vs_rise ? end_x   : ex_q;
      sy_d       = vs_rise ? start_y : sy_q;
      ey_d       = vs_rise ? end_y   : ey_q;
      dx_d       = vs_rise ? decim_x : dx_q;
      dy_d       = vs_rise ? decim_y : dy_q;
      win_ok     = (sx_d < ex_d) && (sy_d < ey_d);

      state_d    = state_q;
      if (vs_rise) state_d = win_ok ? RUN : BAD;

      // Position of the pixel on the input this cycle
      x_cur      = vs_rise ? '0 : x_q;
      y_cur      = vs_rise ? '0 : y_q;
      x_off      = x_cur - sx_d;
      y_off      = y_cur - sy_d;
      x_mask     = ~({X_WIDTH{1'b1}} << dx_d);
      y_mask     = ~({Y_WIDTH{1'b1}} << dy_d);
      last_x     = sx_d + (((ex_d - X_ONE - sx_d) >> dx_d) << dx_d);

      keep       = (state_d == RUN) && vid.de_i
                   && (x_cur >= sx_d) && (x_cur < ex_d)
                   && (y_cur >= sy_d) && (y_cur < ey_d)
                   && ((x_off & x_mask) == '0) && ((y_off & y_mask) == '0);

      // Saturating column/line counters
      x_d        = x_cur;
      y_d        = y_cur;
      if (vid.de_i) begin
         if (x_cur != '1) x_d = x_cur + X_ONE;
      end else if (de_fall && !vs_rise) begin
         x_d = '0;
         if (y_q != '1) y_d = y_q + Y_ONE;
      end

      sof_pend_d = sof_pend_q;
      if (vs_rise) sof_pend_d = 1'b1;
      if (keep)    sof_pend_d = 1'b0;

      out_w_d    = out_w_q;
      out_h_d    = out_h_q;
      if (vs_rise) begin
         out_w_d = win_ok ? ((ex_d - sx_d - X_ONE) >> dx_d) + X_ONE : '0;
         out_h_d = win_ok ? ((ey_d - sy_d - Y_ONE) >> dy_d) + Y_ONE : '0;
      end

      vs_o_d     = vid.vs_i;
      de_o_d     = keep;
      rgb_o_d    = keep ? vid.rgb_i : '0;
      sof_o_d    = keep && (vs_rise || sof_pend_q);
      eol_o_d    = keep && (x_cur == last_x);
      active_d   = (state_d == RUN);
      err_d      = (state_d == BAD);
   end

   // Datapath, shadow window and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         vs_prev_q  <= 1'b0;
         de_prev_q  <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         sx_q       <= '0;
         ex_q       <= '0;
         sy_q       <= '0;
         ey_q       <= '0;
         dx_q       <= '0;
         dy_q       <= '0;
         sof_pend_q <= 1'b0;
         out_w_q    <= '0;
         out_h_q    <= '0;
         vs_o_q     <= 1'b0;
         de_o_q     <= 1'b0;
         rgb_o_q    <= '0;
         sof_o_q    <= 1'b0;
         eol_o_q    <= 1'b0;
         active_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         vs_prev_q  <= vid.vs_i;
         de_prev_q  <= vid.de_i;
         x_q        <= x_d;
         y_q        <= y_d;
         sx_q       <= sx_d;
         ex_q       <= ex_d;
         sy_q       <= sy_d;
         ey_q       <= ey_d;
         dx_q       <= dx_d;
         dy_q       <= dy_d;
         sof_pend_q <= sof_pend_d;
         out_w_q    <= out_w_d;
         out_h_q    <= out_h_d;
         vs_o_q     <= vs_o_d;
         de_o_q     <= de_o_d;
         rgb_o_q    <= rgb_o_d;
         sof_o_q    <= sof_o_d;
         eol_o_q    <= eol_o_d;
         active_q   <= active_d;
         err_q      <= err_d;
      end
   end

   assign vid.vs_o  = vs_o_q;
   assign vid.de_o  = de_o_q;
   assign vid.rgb_o = rgb_o_q;
   assign vid.sof_o = sof_o_q;
   assign vid.eol_o = eol_o_q;
   assign active    = active_q;
   assign err_o     = err_q;
   assign out_w     = out_w_q;
   assign out_h     = out_h_q;
endmodule

// File: tb/tb_video_crop_decim.sv
// Scoreboard bench for video_crop_decim: a default RGB instance and a
// single-channel 10-bit instance, fed with ramp frames.
`timescale 1ns/1ps
module tb_video_crop_decim;
   typedef struct { logic [23:0] rgb; bit sof; bit eol; int cyc; } exp_t;
   typedef struct { int sx; int ex; int sy; int ey; int dx; int dy; bit run; int eol_x; } win_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;
   int n_de[2], n_sof[2], n_eol[2];
   exp_t exp_a[$];
   exp_t exp_b[$];

   logic [11:0] sx_a, ex_a, sy_a, ey_a, sx_b, ex_b, sy_b, ey_b;
   logic [1:0]  dx_a, dy_a, dx_b, dy_b;
   logic        active_a, err_a, active_b, err_b;
   logic [11:0] ow_a, oh_a, ow_b, oh_b;

   video_crop_decim_if #(.PW(24)) vif_a ();
   video_crop_decim_if #(.PW(10)) vif_b ();

   video_crop_decim dut_a (
      .clk(clk), .rst(rst),
      .start_x(sx_a), .end_x(ex_a), .start_y(sy_a), .end_y(ey_a),
      .decim_x(dx_a), .decim_y(dy_a),
      .vid(vif_a),
      .active(active_a), .err_o(err_a), .out_w(ow_a), .out_h(oh_a)
   );

   video_crop_decim #(.DATA_WIDTH(10), .CHANNELS(1)) dut_b (
      .clk(clk), .rst(rst),
      .start_x(sx_b), .end_x(ex_b), .start_y(sy_b), .end_y(ey_b),
      .decim_x(dx_b), .decim_y(dy_b),
      .vid(vif_b),
      .active(active_b), .err_o(err_b), .out_w(ow_b), .out_h(oh_b)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Inputs as seen at the last clock edge, for the 1-clk vs_o delay
   logic rst_s, vsa_s, vsb_s;
   always @(posedge clk) begin
      rst_s <= rst;
      vsa_s <= vif_a.vs_i;
      vsb_s <= vif_b.vs_i;
   end

   task automatic mon_one(input bit sel, input logic vs, input logic de, input logic sof,
                          input logic eol, input logic [23:0] rgb, input logic act,
                          input logic err, input logic [11:0] ow, input logic [11:0] oh);
      exp_t  e;
      string p;
      int    qs;
      p = sel ? "b" : "a";
      check({p, "_vs_o"}, vs, rst_s ? 1'b0 : (sel ? vsb_s : vsa_s));
      if (rst_s) check({p, "_reset_outs"}, {de, sof, eol, rgb, act, err, ow, oh}, 64'd0);
      if (de) begin
         n_de[sel]++;
         if (sof) n_sof[sel]++;
         if (eol) n_eol[sel]++;
         qs = sel ? exp_b.size() : exp_a.size();
         if (qs == 0) begin
            check({p, "_unexpected_de"}, de, 1'b0);
         end else begin
            e = sel ? exp_b.pop_front() : exp_a.pop_front();
            check({p, "_rgb"}, rgb, e.rgb);
            check({p, "_sof_eol"}, {sof, eol}, {e.sof, e.eol});
            check({p, "_latency"}, cyc, e.cyc);
         end
      end else begin
         check({p, "_idle_outs"}, {sof, eol, rgb}, 64'd0);
      end
   endtask

   // Monitor: compare every output cycle of both instances against the scoreboard
   always @(negedge clk) begin
      mon_one(1'b0, vif_a.vs_o, vif_a.de_o, vif_a.sof_o, vif_a.eol_o, vif_a.rgb_o,
              active_a, err_a, ow_a, oh_a);
      mon_one(1'b1, vif_b.vs_o, vif_b.de_o, vif_b.sof_o, vif_b.eol_o, {14'd0, vif_b.rgb_o},
              active_b, err_b, ow_b, oh_b);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit sel, input logic vs, input logic de,
                        input logic [23:0] pix, input logic r);
      rst = r;
      if (sel) begin
         vif_b.vs_i  = vs;
         vif_b.de_i  = de;
         vif_b.rgb_i = pix[9:0];
      end else begin
         vif_a.vs_i  = vs;
         vif_a.de_i  = de;
         vif_a.rgb_i = pix;
      end
   endtask

   function automatic logic [23:0] mkpix(input bit sel, input int x, input int y);
      if (sel) return 24'(y * 64 + x);
      return {8'(y), 8'(x), 8'(x + y + 1)};
   endfunction

   task automatic set_win_a(input int sx, input int ex, input int sy, input int ey,
                            input int dx, input int dy);
      sx_a = 12'(sx); ex_a = 12'(ex); sy_a = 12'(sy); ey_a = 12'(ey);
      dx_a = 2'(dx);  dy_a = 2'(dy);
   endtask

   // One frame: vs pulse (or vs concurrent with the first pixel), then h lines of w
   // pixels with 3-cycle blanking. Pixels expected out are pushed as they are driven.
   task automatic run_frame(input bit sel, input int w, input int h, input win_t win,
                            input bit vs_on_de, input int chg_line, input int chg_sx,
                            input int rst_y, input int rst_x);
      bit          first;
      bit          live;
      logic [23:0] pix;
      logic        vs, r;
      exp_t        e;
      first = 1'b1;
      live  = win.run;
      n_de  = '{0, 0};
      n_sof = '{0, 0};
      n_eol = '{0, 0};
      if (!vs_on_de) begin
         repeat (2) begin step(); drive(sel, 1'b1, 1'b0, 24'd0, 1'b0); end
         repeat (2) begin step(); drive(sel, 1'b0, 1'b0, 24'd0, 1'b0); end
      end
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < w; x++) begin
            step();
            vs  = vs_on_de && (y == 0) && (x < 2);
            r   = (y == rst_y) && (x == rst_x);
            pix = mkpix(sel, x, y);
            drive(sel, vs, 1'b1, pix, r);
            if (r) live = 1'b0;
            if (live && x >= win.sx && x < win.ex && y >= win.sy && y < win.ey
                && ((x - win.sx) % (1 << win.dx)) == 0
                && ((y - win.sy) % (1 << win.dy)) == 0) begin
               e.rgb = pix;
               e.sof = first;
               e.eol = (x == win.eol_x);
               e.cyc = cyc + 1;
               if (sel) exp_b.push_back(e);
               else     exp_a.push_back(e);
               first = 1'b0;
            end
         end
         repeat (3) begin step(); drive(sel, 1'b0, 1'b0, 24'd0, 1'b0); end
         if (y == chg_line) sx_a = 12'(chg_sx);
      end
      repeat (2) begin step(); drive(sel, 1'b0, 1'b0, 24'd0, 1'b0); end
   endtask

   task automatic frame_checks(input bit sel, input string tag, input int de, input int sof,
                               input int eol, input int ow, input int oh,
                               input bit act, input bit err);
      check({tag, "_de_count"},  n_de[sel], de);
      check({tag, "_sof_count"}, n_sof[sel], sof);
      check({tag, "_eol_count"}, n_eol[sel], eol);
      check({tag, "_pending"},   sel ? exp_b.size() : exp_a.size(), 0);
      check({tag, "_out_w"},     sel ? ow_b : ow_a, ow);
      check({tag, "_out_h"},     sel ? oh_b : oh_a, oh);
      check({tag, "_active"},    sel ? active_b : active_a, act);
      check({tag, "_err_o"},     sel ? err_b : err_a, err);
   endtask

   initial begin
      win_t w_crop, w_dec1, w_bad, w_full_x, w_dec3, w_vsde, w_b;
      w_crop   = '{10, 20, 4, 8, 0, 0, 1'b1, 19};
      w_dec1   = '{10, 20, 4, 8, 1, 1, 1'b1, 18};
      w_bad    = '{20, 20, 4, 8, 0, 0, 1'b0, -1};
      w_full_x = '{0, 20, 4, 8, 0, 0, 1'b1, 19};
      w_dec3   = '{0, 32, 0, 12, 3, 2, 1'b1, 24};
      w_vsde   = '{0, 4, 0, 2, 0, 0, 1'b1, 3};
      w_b      = '{0, 64, 0, 4, 0, 0, 1'b1, 63};

      rst = 1'b1;
      vif_a.vs_i = 1'b0; vif_a.de_i = 1'b0; vif_a.rgb_i = '0;
      vif_b.vs_i = 1'b0; vif_b.de_i = 1'b0; vif_b.rgb_i = '0;
      set_win_a(10, 20, 4, 8, 0, 0);
      sx_b = 12'd0; ex_b = 12'd64; sy_b = 12'd0; ey_b = 12'd4; dx_b = 2'd0; dy_b = 2'd0;
      repeat (3) step();
      rst = 1'b0;
      repeat (2) step();

      check("reset_active", active_a, 1'b0);
      check("reset_err",    err_a, 1'b0);
      check("reset_out_w",  ow_a, 12'd0);
      check("reset_out_h",  oh_a, 12'd0);
      check("reset_de_o",   vif_a.de_o, 1'b0);

      // Active video without a frame start produces nothing
      n_de = '{0, 0};
      repeat (20) begin step(); drive(1'b0, 1'b0, 1'b1, 24'h123456, 1'b0); end
      repeat (3)  begin step(); drive(1'b0, 1'b0, 1'b0, 24'd0, 1'b0); end
      check("no_vs_de_count", n_de[0], 0);

      run_frame(1'b0, 32, 12, w_crop, 1'b0, -1, 0, -1, -1);
      frame_checks(1'b0, "crop", 40, 1, 4, 10, 4, 1'b1, 1'b0);

      set_win_a(10, 20, 4, 8, 1, 1);
      run_frame(1'b0, 32, 12, w_dec1, 1'b0, -1, 0, -1, -1);
      frame_checks(1'b0, "decim1", 10, 1, 2, 5, 2, 1'b1, 1'b0);

      set_win_a(20, 20, 4, 8, 0, 0);
      run_frame(1'b0, 32, 12, w_bad, 1'b0, -1, 0, -1, -1);
      frame_checks(1'b0, "bad", 0, 0, 0, 0, 0, 1'b0, 1'b1);

      set_win_a(10, 20, 4, 8, 0, 0);
      run_frame(1'b0, 32, 12, w_crop, 1'b0, -1, 0, -1, -1);
      frame_checks(1'b0, "recover", 40, 1, 4, 10, 4, 1'b1, 1'b0);

      // start_x moved to 0 mid-frame only takes effect at the next frame start
      run_frame(1'b0, 32, 12, w_crop, 1'b0, 5, 0, -1, -1);
      frame_checks(1'b0, "midchg", 40, 1, 4, 10, 4, 1'b1, 1'b0);
      run_frame(1'b0, 32, 12, w_full_x, 1'b0, -1, 0, -1, -1);
      frame_checks(1'b0, "newwin", 80, 1, 4, 20, 4, 1'b1, 1'b0);

      set_win_a(0, 32, 0, 12, 3, 2);
      run_frame(1'b0, 32, 12, w_dec3, 1'b0, -1, 0, -1, -1);
      frame_checks(1'b0, "decim3", 12, 1, 3, 4, 3, 1'b1, 1'b0);

      set_win_a(0, 4, 0, 2, 0, 0);
      run_frame(1'b0, 8, 4, w_vsde, 1'b1, -1, 0, -1, -1);
      frame_checks(1'b0, "vs_with_de", 8, 1, 2, 4, 2, 1'b1, 1'b0);

      // Reset in the middle of line 5; the rest of the frame must stay silent
      set_win_a(10, 20, 4, 8, 0, 0);
      run_frame(1'b0, 32, 12, w_crop, 1'b0, -1, 0, 5, 12);
      frame_checks(1'b0, "midline_rst", 12, 1, 1, 0, 0, 1'b0, 1'b0);
      run_frame(1'b0, 32, 12, w_crop, 1'b0, -1, 0, -1, -1);
      frame_checks(1'b0, "post_rst", 40, 1, 4, 10, 4, 1'b1, 1'b0);

      // Single 10-bit channel, full-frame window
      run_frame(1'b1, 64, 4, w_b, 1'b0, -1, 0, -1, -1);
      frame_checks(1'b1, "mono_full", 256, 1, 4, 64, 4, 1'b1, 1'b0);

      repeat (2) step();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
